// File: rtl/integrator_comb_decimator.sv
// Single-stage CIC back end: decimates the integrator sum by DECIM_R, applies an
// COMB_M-delay comb and buffers results in a 2-entry valid/ready output stage.
// Define COMB_OVERRUN_FLAG_EN to add the sticky 'overrun' drop flag port.
module integrator_comb_decimator #(
  parameter int DECIM_R = 4,
  parameter int COMB_M  = 1,
  parameter int DATA_W  = 10
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef COMB_OVERRUN_FLAG_EN
  ,
  output logic              overrun
`endif
);

  localparam int               CNT_W    = $clog2(DECIM_R);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM_R - 1);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dly [COMB_M];
  logic              dec_fire;
  logic              pop;
  logic [DATA_W-1:0] diff;

  logic              head_v, tail_v;
  logic [DATA_W-1:0] head_q, tail_q;
  logic              head_v_d, tail_v_d;
  logic [DATA_W-1:0] head_d, tail_d;

  assign dec_fire = in_valid && (cnt == CNT_LAST);
  assign pop      = head_v && out_ready;
  // Modular subtraction undoes the integrator's own wrap-around.
  assign diff     = in_data - dly[COMB_M-1];

  assign out_valid = head_v;
  assign out_data  = head_q;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // NOTE: the delay line is reset like any other register: the first comb
  // output after reset must see zero history, not whatever was left behind.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < COMB_M; i++) dly[i] <= '0;
    end else if (dec_fire) begin
      dly[0] <= in_data;
      for (int i = 1; i < COMB_M; i++) dly[i] <= dly[i-1];
    end
  end

  // Head register drives the outputs and keeps the last popped value when
  // the buffer drains; the tail only ever feeds the head.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    head_v_d = head_v;
    tail_v_d = tail_v;
    head_d   = head_q;
    tail_d   = tail_q;
    if (!head_v) begin
      if (dec_fire) begin
        head_d   = diff;
        head_v_d = 1'b1;
      end
    end else if (!tail_v) begin
      if (pop && dec_fire) begin
        head_d = diff;
      end else if (pop) begin
        head_v_d = 1'b0;
      end else if (dec_fire) begin
        tail_d   = diff;
        tail_v_d = 1'b1;
      end
    end else if (pop) begin
      head_d   = tail_q;
      tail_v_d = dec_fire;
      if (dec_fire) tail_d = diff;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      head_v <= 1'b0;
      tail_v <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_v <= head_v_d;
      tail_v <= tail_v_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifdef COMB_OVERRUN_FLAG_EN
  logic drop;

  // Full with no pop: the new diff is lost, though comb history still advances.
  assign drop = head_v && tail_v && !pop && dec_fire;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_integrator_comb_decimator.sv
// Scoreboard bench: dut_a (R=4, M=1) and dut_b (R=4, M=2) share clock and reset;
// directed stimulus pushes hand-computed diffs, per-DUT monitors pop and compare.
module tb_integrator_comb_decimator;
  localparam int W = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic         a_in_valid, a_out_valid, a_out_ready;
  logic         b_in_valid, b_out_valid, b_out_ready;
`ifdef COMB_OVERRUN_FLAG_EN
  logic         a_overrun, b_overrun;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  integrator_comb_decimator #(.DECIM_R(4), .COMB_M(1), .DATA_W(W)) dut_a (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .in_data         (a_in_data),
    .in_valid        (a_in_valid),
    .out_data        (a_out_data),
    .out_valid       (a_out_valid),
    .out_ready       (a_out_ready)
`ifdef COMB_OVERRUN_FLAG_EN
    ,
    .overrun         (a_overrun)
`endif
  );

  integrator_comb_decimator #(.DECIM_R(4), .COMB_M(2), .DATA_W(W)) dut_b (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .in_data         (b_in_data),
    .in_valid        (b_in_valid),
    .out_data        (b_out_data),
    .out_valid       (b_out_valid),
    .out_ready       (b_out_ready)
`ifdef COMB_OVERRUN_FLAG_EN
    ,
    .overrun         (b_overrun)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitors sample on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rstn && a_out_valid && a_out_ready) begin
      check("a_expected_pending", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) check("a_out_data", 32'(a_out_data), 32'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rstn && b_out_valid && b_out_ready) begin
      check("b_expected_pending", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) check("b_out_data", 32'(b_out_data), 32'(qb.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_a(input logic v, input int d);
    a_in_valid = v;
    a_in_data  = W'(d);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic step_b(input logic v, input int d);
    b_in_valid = v;
    b_in_data  = W'(d);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      idle(1);
    end
    check({name, "_a_drained"}, 32'(qa.size()), 0);
    check({name, "_b_drained"}, 32'(qb.size()), 0);
    qa.delete();
    qb.delete();
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    a_in_data   = '0;
    b_in_data   = '0;
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_a_valid", 32'(a_out_valid), 0);
    check("rst_a_data",  32'(a_out_data), 0);
    check("rst_b_valid", 32'(b_out_valid), 0);
    check("rst_b_data",  32'(b_out_data), 0);
`ifdef COMB_OVERRUN_FLAG_EN
    check("rst_a_overrun", 32'(a_overrun), 0);
`endif

    // Constant ramp of step 3: diffs 12,12,12, one cycle after inputs 4, 8, 12
    qa.push_back(10'd12); qa.push_back(10'd12); qa.push_back(10'd12);
    vcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step_a(1'b1, 3 * i);
      if (a_out_valid) vcnt++;
      if (i == 4) check("ramp_latency", 32'(a_out_valid), 1);
      if (i == 3) check("ramp_not_early", 32'(a_out_valid), 0);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      if (a_out_valid) vcnt++;
    end
    check("ramp_valid_cycles", 32'(vcnt), 3);
    drain("ramp");

    // Wrap-around: 508 then -500 -> 508, then (-500 - 508) mod 1024 = 16
    do_reset();
    qa.push_back(10'd508); qa.push_back(10'd16);
    step_a(1, 0); step_a(1, 0); step_a(1, 0); step_a(1, 508);
    step_a(1, 0); step_a(1, 0); step_a(1, 0); step_a(1, -500);
    drain("wrap");

    // Backpressure: two diffs buffered, third dropped, history kept
    do_reset();
    a_out_ready = 1'b0;
    qa.push_back(10'd12); qa.push_back(10'd12);
    for (int i = 1; i <= 12; i++) step_a(1'b1, 3 * i);
    check("bp_full_valid", 32'(a_out_valid), 1);
    check("bp_full_head",  32'(a_out_data), 12);
`ifdef COMB_OVERRUN_FLAG_EN
    check("bp_overrun_set", 32'(a_overrun), 1);
`endif
    a_out_ready = 1'b1;
    idle(3);
    check("bp_popped_both", 32'(qa.size()), 0);
    check("bp_empty_valid", 32'(a_out_valid), 0);
    check("bp_hold_last",   32'(a_out_data), 12);
    qa.push_back(10'd12);
    for (int i = 13; i <= 16; i++) step_a(1'b1, 3 * i);
    drain("bp");
`ifdef COMB_OVERRUN_FLAG_EN
    check("bp_overrun_sticky", 32'(a_overrun), 1);
`endif

    // Push and pop on the same edge while full: nothing dropped
    do_reset();
    a_out_ready = 1'b0;
    qa.push_back(10'd10); qa.push_back(10'd20); qa.push_back(10'd30);
    for (int i = 1; i <= 11; i++) step_a(1'b1, (i == 4) ? 10 : (i == 8) ? 30 : 0);
    a_out_ready = 1'b1;
    step_a(1'b1, 60);
    check("pp_head_advanced", 32'(a_out_data), 20);
    check("pp_valid",         32'(a_out_valid), 1);
`ifdef COMB_OVERRUN_FLAG_EN
    check("pp_no_overrun", 32'(a_overrun), 0);
`endif
    drain("pp");

    // Mid-run reset with buffer full and counter mid-phase
    a_out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) step_a(1'b1, 3 * i);
    check("mr_pre_valid", 32'(a_out_valid), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("mr_async_valid", 32'(a_out_valid), 0);
    check("mr_async_data",  32'(a_out_data), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    qa.push_back(10'd100);
    step_a(1, 5); step_a(1, 5); step_a(1, 5);
    check("mr_phase0_quiet", 32'(a_out_valid), 0);
    step_a(1, 100);
    check("mr_first_valid", 32'(a_out_valid), 1);
    check("mr_first_data",  32'(a_out_data), 100);
    drain("mr");

    // COMB_M=2 with in_valid gaps: decimated 12,24,36,48 -> 12,24,24,24
    b_out_ready = 1'b1;
    qb.push_back(10'd12); qb.push_back(10'd24); qb.push_back(10'd24); qb.push_back(10'd24);
    for (int i = 1; i <= 16; i++) begin
      step_b(1'b1, 3 * i);
      if (i == 5 || i == 10) begin
        step_b(1'b0, 999);
        step_b(1'b0, 7);
      end
    end
    drain("m2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
